// File: rtl/sram_like_arbiter_pkg.sv
// Shared encodings for the sram-like arbiter slice: transfer sizes, FSM states, index widths.
// No logic; constants and a width helper only.
// No flow control of its own.
package sram_like_arbiter_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/sram_like_arbiter_if.sv
// Flattened N-master sram-like request/response bundle plus the single slave-side port.
// Wires only, no latency.
// slave modport is the arbiter's view; master modport is the CPU/bridge environment.
interface sram_like_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
);
    logic [NUM_MASTERS-1:0]            m_req;
    logic [NUM_MASTERS-1:0]            m_wr;
    logic [2*NUM_MASTERS-1:0]          m_size;
    logic [(DATA_W/8)*NUM_MASTERS-1:0] m_wstrb;
    logic [ADDR_W*NUM_MASTERS-1:0]     m_addr;
    logic [DATA_W*NUM_MASTERS-1:0]     m_wdata;
    logic [NUM_MASTERS-1:0]            m_addr_ok;
    logic [NUM_MASTERS-1:0]            m_data_ok;
    logic [DATA_W-1:0]                 m_rdata;

    logic                              s_req;
    logic                              s_wr;
    logic [1:0]                        s_size;
    logic [DATA_W/8-1:0]               s_wstrb;
    logic [ADDR_W-1:0]                 s_addr;
    logic [DATA_W-1:0]                 s_wdata;
    logic                              s_addr_ok;
    logic                              s_data_ok;
    logic [DATA_W-1:0]                 s_rdata;

    modport slave (
        input  m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
        output m_addr_ok, m_data_ok, m_rdata,
        output s_req, s_wr, s_size, s_wstrb, s_addr, s_wdata,
        input  s_addr_ok, s_data_ok, s_rdata
    );

    modport master (
        output m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
        input  m_addr_ok, m_data_ok, m_rdata,
        input  s_req, s_wr, s_size, s_wstrb, s_addr, s_wdata,
        output s_addr_ok, s_data_ok, s_rdata
    );
endinterface

// File: rtl/sram_like_order_fifo.sv
// Order FIFO holding the master index of each accepted request, oldest at the head.
// Head visible combinationally; push/pop take effect at the next clock.
// Push ignored when full, pop ignored when empty; no bypass when full.
module sram_like_order_fifo
    import sram_like_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_dat,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_dat,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = idx_w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// N-master to 1-slave sram-like arbiter, in-order response routing; SRAM_ARB_RR_EN selects round-robin.
// Zero latency: addr_ok/data_ok and slave fields are combinational from the current cycle.
// s_req held low once MAX_OUTSTANDING are in flight; a stalled grant is locked until accepted.
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS     = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32
) (
    input  logic                                   clk,
    input  logic                                   reset,
    sram_like_arbiter_if.slave                     bus,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
    output logic                                   err_unexp
);
    localparam int IDX_W  = idx_w(NUM_MASTERS);
    localparam int STRB_W = DATA_W/8;

    arb_state_t       state;
    logic [IDX_W-1:0] lock_idx;
    logic [IDX_W-1:0] arb_idx;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] head_idx;
    logic             can_issue;
    logic             accept;
    logic             resp;
    logic             fifo_full;
    logic             fifo_empty;

`ifdef SRAM_ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr;
    logic             arb_found;

    always_comb begin
        arb_idx   = '0;
        arb_found = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!arb_found && bus.m_req[(int'(rr_ptr) + i) % NUM_MASTERS]) begin
                arb_found = 1'b1;
                arb_idx   = IDX_W'((int'(rr_ptr) + i) % NUM_MASTERS);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)       rr_ptr <= '0;
        else if (accept) rr_ptr <= (grant == IDX_W'(NUM_MASTERS-1)) ? '0 : grant + 1'b1;
    end
`else
    always_comb begin
        arb_idx = '0;
        for (int i = NUM_MASTERS-1; i >= 0; i--) begin
            if (bus.m_req[i]) arb_idx = IDX_W'(i);
        end
    end
`endif

    assign can_issue = !fifo_full;
    assign grant     = (state == ST_LOCKED) ? lock_idx : arb_idx;
    assign bus.s_req = can_issue && ((state == ST_LOCKED) ? bus.m_req[lock_idx] : |bus.m_req);
    assign accept    = bus.s_req && bus.s_addr_ok;
    assign resp      = bus.s_data_ok && !fifo_empty;

    assign bus.s_wr    = bus.m_wr[grant];
    assign bus.s_size  = bus.m_size[int'(grant)*2 +: 2];
    assign bus.s_wstrb = bus.m_wstrb[int'(grant)*STRB_W +: STRB_W];
    assign bus.s_addr  = bus.m_addr[int'(grant)*ADDR_W +: ADDR_W];
    assign bus.s_wdata = bus.m_wdata[int'(grant)*DATA_W +: DATA_W];
    assign bus.m_rdata = bus.s_rdata;

    always_comb begin
        bus.m_addr_ok = '0;
        bus.m_data_ok = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            bus.m_addr_ok[i] = accept && (int'(grant) == i);
            bus.m_data_ok[i] = resp && (int'(head_idx) == i);
        end
    end

    // Lock holds the grant stable while the slave stalls so fields cannot change mid-request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            lock_idx  <= '0;
            err_unexp <= 1'b0;
        end else begin
            if (bus.s_data_ok && fifo_empty) err_unexp <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (bus.s_req && !bus.s_addr_ok) begin
                        state    <= ST_LOCKED;
                        lock_idx <= arb_idx;
                    end
                end
                ST_LOCKED: begin
                    if (accept || !bus.m_req[lock_idx]) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    sram_like_order_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDX_W)
    ) u_order_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (accept),
        .push_dat (grant),
        .pop      (resp),
        .pop_dat  (head_idx),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (outstanding)
    );

endmodule
